// File: rtl/ram_arbiter.sv
// Purpose: two-requester round-robin arbiter in front of a single-port async RAM with a shared tri-state data bus.
// Latency: write response 2 cycles after accept, read response 3 cycles after accept (rdata captured at end of RD1).
// Backpressure: req_ready only in IDLE for one cycle to the granted requester; no new grant until the access completes.
module ram_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              req_valid,
    input  logic [1:0]              req_we,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              req_ready,
    output logic [1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    busy,
    output logic                    ram_chip_select,
    output logic                    ram_write_enable,
    output logic                    ram_output_enable,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    inout  wire  [DATA_WIDTH-1:0]   ram_data
);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD0, S_RD1, S_DONE} state_t;

    state_t                r_state;
    logic                  r_gnt;
    logic                  r_last;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rsp_vld;
    logic                  r_busy;
    logic                  r_cs;
    logic                  r_we;
    logic                  r_oe;
    logic                  r_drive;

    logic                  w_gnt;
    logic                  w_accept;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;

    // Round-robin pick: on a tie the requester not served last wins.
    always_comb begin
        w_gnt = 1'b0;
        if (req_valid == 2'b11) begin
            w_gnt = ~r_last;
        end else if (req_valid[1]) begin
            w_gnt = 1'b1;
        end
    end

    // Accept is gated by rst_n so no ready strobe leaks out while reset is held.
    assign w_accept = rst_n && (r_state == S_IDLE) && (req_valid != 2'b00);
    assign w_we     = w_gnt ? req_we[1] : req_we[0];
    assign w_addr   = w_gnt ? req_addr[ADDR_WIDTH +: ADDR_WIDTH] : req_addr[0 +: ADDR_WIDTH];
    assign w_wdata  = w_gnt ? req_wdata[DATA_WIDTH +: DATA_WIDTH] : req_wdata[0 +: DATA_WIDTH];

    // One-hot accept strobe toward the granted requester only.
    always_comb begin
        req_ready = 2'b00;
        if (w_accept) begin
            req_ready[w_gnt] = 1'b1;
        end
    end

    // Access sequencer: RAM controls are registered together with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_gnt     <= 1'b0;
            r_last    <= 1'b1;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_rsp_vld <= 2'b00;
            r_busy    <= 1'b0;
            r_cs      <= 1'b0;
            r_we      <= 1'b0;
            r_oe      <= 1'b0;
            r_drive   <= 1'b0;
        end else begin
            r_rsp_vld <= 2'b00;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_gnt   <= w_gnt;
                        r_addr  <= w_addr;
                        r_wdata <= w_wdata;
                        r_busy  <= 1'b1;
                        r_cs    <= 1'b1;
                        if (w_we) begin
                            r_state <= S_WR;
                            r_we    <= 1'b1;
                            r_drive <= 1'b1;
                        end else begin
                            r_state <= S_RD0;
                            r_oe    <= 1'b1;
                        end
                    end
                end
                S_WR: begin
                    r_state          <= S_DONE;
                    r_cs             <= 1'b0;
                    r_we             <= 1'b0;
                    r_drive          <= 1'b0;
                    r_rsp_vld[r_gnt] <= 1'b1;
                end
                S_RD0: begin
                    r_state <= S_RD1;
                end
                S_RD1: begin
                    r_state          <= S_DONE;
                    r_rdata          <= ram_data;
                    r_cs             <= 1'b0;
                    r_oe             <= 1'b0;
                    r_rsp_vld[r_gnt] <= 1'b1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_last  <= r_gnt;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid         = r_rsp_vld;
    assign rsp_rdata         = r_rdata;
    assign busy              = r_busy;
    assign ram_chip_select   = r_cs;
    assign ram_write_enable  = r_we;
    assign ram_output_enable = r_oe;
    assign ram_addr          = r_addr;
    // Bus is driven only during the write cycle, never while output enable is high.
    assign ram_data          = r_drive ? r_wdata : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_ram_arbiter.sv
`timescale 1ns/1ps
module tb_ram_arbiter;
    localparam int AW = 10;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0]      req_valid = '0;
    logic [1:0]      req_we = '0;
    logic [2*AW-1:0] req_addr = '0;
    logic [2*DW-1:0] req_wdata = '0;
    wire  [1:0]      req_ready;
    wire  [1:0]      rsp_valid;
    wire  [DW-1:0]   rsp_rdata;
    wire             busy;
    wire             ram_chip_select;
    wire             ram_write_enable;
    wire             ram_output_enable;
    wire  [AW-1:0]   ram_addr;
    wire  [DW-1:0]   ram_data;

    ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .ram_chip_select(ram_chip_select), .ram_write_enable(ram_write_enable),
        .ram_output_enable(ram_output_enable), .ram_addr(ram_addr), .ram_data(ram_data)
    );

    always #5 clk = ~clk;

    // External single-port RAM: async read when selected with output enable, write on clock edge.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) if (ram_chip_select && ram_write_enable) mem[ram_addr] <= ram_data;
    assign ram_data = (ram_chip_select && ram_output_enable && !ram_write_enable) ? mem[ram_addr] : {DW{1'bz}};

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Transaction-timeline reference: each accepted request owns a fixed window of cycles.
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    bit            m_has = 0;
    bit            m_wr = 0;
    int            m_t = 0;
    int            m_g = 0;
    int            m_last = 1;
    int            m_idle_at = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_val = '0;
    logic [DW-1:0] m_rdata = '0;
    logic [1:0]    obs_ready = '0;

    always @(negedge clk) begin : cmp
        logic [1:0] e_ready, e_rsp;
        logic e_busy, e_cs, e_we, e_oe;
        int d, g;
        e_ready = '0; e_rsp = '0; e_busy = 0; e_cs = 0; e_we = 0; e_oe = 0; g = 0; d = 0;
        if (!rst_n) begin
            m_has = 0; m_last = 1; m_addr = '0; m_rdata = '0; m_idle_at = cyc + 1;
        end else begin
            e_busy = m_has && (cyc < m_idle_at);
            if (m_has) begin
                d = cyc - m_t;
                if (m_wr) begin
                    if (d == 1) begin e_cs = 1; e_we = 1; chk("wr_bus", 32'(ram_data), 32'(m_val)); end
                    if (d == 2) e_rsp[m_g] = 1'b1;
                end else begin
                    if (d == 1 || d == 2) begin e_cs = 1; e_oe = 1; chk("rd_bus", 32'(ram_data), 32'(m_val)); end
                    if (d == 3) begin e_rsp[m_g] = 1'b1; m_rdata = m_val; end
                end
            end
            if (!e_busy && req_valid != 2'b00) begin
                g = (req_valid == 2'b11) ? (1 - m_last) : (req_valid[1] ? 1 : 0);
                e_ready[g] = 1'b1;
            end
        end
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("ram_cs", 32'(ram_chip_select), 32'(e_cs));
        chk("ram_we", 32'(ram_write_enable), 32'(e_we));
        chk("ram_oe", 32'(ram_output_enable), 32'(e_oe));
        chk("ram_addr", 32'(ram_addr), 32'(m_addr));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
        obs_ready = req_ready;
        if (rst_n && e_ready != 2'b00) begin
            m_has = 1; m_t = cyc; m_g = g; m_last = g; m_wr = req_we[g];
            m_addr = g ? req_addr[AW +: AW] : req_addr[0 +: AW];
            if (m_wr) begin
                m_val = g ? req_wdata[DW +: DW] : req_wdata[0 +: DW];
                ref_mem[m_addr] = m_val;
                m_idle_at = cyc + 3;
            end else begin
                m_val = ref_mem[m_addr];
                m_idle_at = cyc + 4;
            end
        end
        cyc++;
    end

    // Issue one request from requester i and measure accept-to-response latency.
    task automatic do_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] dat,
                          output int lat, output logic [DW-1:0] rd, output logic [DW-1:0] bus);
        int t0;
        bit done;
        t0 = -1; lat = -1; rd = '0; bus = '0; done = 0;
        @(posedge clk); #1;
        req_valid[i] = 1'b1; req_we[i] = w;
        req_addr[i*AW +: AW] = a; req_wdata[i*DW +: DW] = dat;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (t0 < 0 && req_ready[i]) t0 = k;
            if (ram_chip_select && ram_write_enable) bus = ram_data;
            if (rsp_valid[i]) begin lat = k - t0; rd = rsp_rdata; done = 1; end
            @(posedge clk); #1;
            if (t0 >= 0) req_valid[i] = 1'b0;
        end
        if (!done) chk("req_timeout", 32'd0, 32'd1);
    endtask

    logic [DW-1:0] fill [16];
    int            lat;
    logic [DW-1:0] rd, bus;
    int            gr [4];
    int            ng;
    bit            got;
    bit            pend [2];

    initial begin
        // Reset values while requests are asserted
        repeat (2) @(posedge clk);
        #1 req_valid = 2'b11;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        chk("rst_rdata", 32'(rsp_rdata), 32'd0);
        @(posedge clk); #1 req_valid = '0; rst_n = 1'b1;

        // Requester 0 writes A5 to 3, requester 1 reads it back
        do_req(0, 1'b1, 10'h003, 8'hA5, lat, rd, bus);
        chk("wr_latency", 32'(lat), 32'd2);
        chk("wr_bus_A5", 32'(bus), 32'hA5);
        do_req(1, 1'b0, 10'h003, 8'h00, lat, rd, bus);
        chk("rd_latency", 32'(lat), 32'd3);
        chk("rd_data_A5", 32'(rd), 32'hA5);

        // Fresh reset, then both requesters valid continuously
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        req_we = 2'b11; req_addr = {10'h021, 10'h020}; req_wdata = {8'h11, 8'h10}; req_valid = 2'b11;
        ng = 0;
        for (int k = 0; k < 40 && ng < 4; k++) begin
            @(negedge clk);
            if (req_ready[0]) begin gr[ng] = 0; ng++; end
            else if (req_ready[1]) begin gr[ng] = 1; ng++; end
            @(posedge clk); #1;
        end
        req_valid = '0;
        chk("alt_count", 32'(ng), 32'd4);
        chk("alt_g0", 32'(gr[0]), 32'd0);
        chk("alt_g1", 32'(gr[1]), 32'd1);
        chk("alt_g2", 32'(gr[2]), 32'd0);
        chk("alt_g3", 32'(gr[3]), 32'd1);
        repeat (5) @(posedge clk);

        // Fill 0..15 and read back
        for (int a = 0; a < 16; a++) begin
            fill[a] = DW'($urandom);
            do_req(int'($urandom_range(1)), 1'b1, AW'(a), fill[a], lat, rd, bus);
        end
        for (int a = 0; a < 16; a++) begin
            do_req(int'($urandom_range(1)), 1'b0, AW'(a), 8'h00, lat, rd, bus);
            chk("readback", 32'(rd), 32'(fill[a]));
        end

        // Reset asserted during RD0
        @(posedge clk); #1;
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0 +: AW] = 10'h005;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            got = req_ready[0];
        end
        chk("rd0_accept", 32'(got), 32'd1);
        @(posedge clk); #2 rst_n = 1'b0; req_valid = '0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_cs", 32'(ram_chip_select), 32'd0);
        chk("abort_oe", 32'(ram_output_enable), 32'd0);
        chk("abort_addr", 32'(ram_addr), 32'd0);
        chk("abort_rsp", 32'(rsp_valid), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        do_req(1, 1'b0, 10'h005, 8'h00, lat, rd, bus);
        chk("post_abort_lat", 32'(lat), 32'd3);
        chk("post_abort_data", 32'(rd), 32'(fill[5]));

        // Requester 1 pulses valid only while requester 0's write is in WR
        @(posedge clk); #1;
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0 +: AW] = 10'h007; req_wdata[0 +: DW] = 8'h3C;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            got = req_ready[0];
        end
        chk("wr7_accept", 32'(got), 32'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0; req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[AW +: AW] = 10'h002;
        @(negedge clk);
        chk("wr_no_grant1", 32'(req_ready), 32'd0);
        chk("wr_busy", 32'(busy), 32'd1);
        @(posedge clk); #1 req_valid[1] = 1'b0;
        @(negedge clk);
        chk("done_rsp0", 32'(rsp_valid), 32'd1);
        chk("done_no_grant", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_no_rsp1", 32'(rsp_valid), 32'd0);

        // Random traffic with occasional abandoned requests
        pend[0] = 0; pend[1] = 0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (pend[i] && obs_ready[i]) begin
                    pend[i] = 0; req_valid[i] = 1'b0;
                end else if (pend[i] && $urandom_range(15) == 0) begin
                    pend[i] = 0; req_valid[i] = 1'b0;
                end
                if (!pend[i] && $urandom_range(2) == 0) begin
                    req_we[i] = 1'($urandom_range(1));
                    req_addr[i*AW +: AW] = AW'($urandom_range(15));
                    req_wdata[i*DW +: DW] = DW'($urandom);
                    req_valid[i] = 1'b1;
                    pend[i] = 1;
                end
            end
        end
        @(posedge clk); #1 req_valid = '0;
        repeat (6) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
